// File: rtl/uniform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uniform_pkg
//  Description : Shared types, constants and mask-counting helpers for the
//                uniform rejection-sampling path (sampler -> compactor).
//  Revision    : 1.0  initial release
// ============================================================================
package uniform_pkg;

    localparam int CAND_BITS = 16;
    localparam int KYBER_N   = 256;
    localparam int KYBER_Q   = 3329;

    // Widest mask the helpers below accept; narrower masks are zero-extended.
    localparam int MAX_LANES = 64;

    typedef logic [CAND_BITS-1:0] coef_t;

    // Number of set bits strictly below position idx. This is the write
    // offset of lane idx inside the packed output when lane idx is accepted.
    function automatic int ones_below(input logic [MAX_LANES-1:0] mask,
                                      input int                   idx);
        int n;
        n = 0;
        for (int b = 0; b < MAX_LANES; b++) begin
            if ((b < idx) && mask[b]) begin
                n++;
            end
        end
        return n;
    endfunction

    function automatic int popcount(input logic [MAX_LANES-1:0] mask);
        return ones_below(mask, MAX_LANES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uniform_lane_packer.sv
`default_nettype none
// ============================================================================
//  Module      : uniform_lane_packer
//  Description : Combinational prefix-sum network. For every candidate lane
//                it produces the write offset (number of accepted lanes below
//                it), a keep bit (accepted and within the remaining-coefficient
//                limit), the lane data gated by keep, and the total kept count.
//  Ports       : i_mask      per-lane accept bits
//                i_data      LANES candidates, lane i at [i*CAND_BITS +: CAND_BITS]
//                i_limit     maximum number of lanes that may be kept
//                o_keep      per-lane keep bits (first i_limit accepted lanes)
//                o_offset    per-lane offset, lane i at [i*OFF_W +: OFF_W]
//                o_lane_data i_data with dropped lanes forced to zero
//                o_n_acc     min(popcount(i_mask), i_limit)
//  Revision    : 1.0  initial release
// ============================================================================
module uniform_lane_packer #(
    parameter int LANES     = 8,
    parameter int CAND_BITS = uniform_pkg::CAND_BITS,
    parameter int OFF_W     = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]           i_mask,
    input  logic [LANES*CAND_BITS-1:0] i_data,
    input  logic [OFF_W-1:0]           i_limit,
    output logic [LANES-1:0]           o_keep,
    output logic [LANES*OFF_W-1:0]     o_offset,
    output logic [LANES*CAND_BITS-1:0] o_lane_data,
    output logic [OFF_W-1:0]           o_n_acc
);
    import uniform_pkg::*;

    logic [MAX_LANES-1:0] w_mask_ext;
    logic [OFF_W-1:0]     w_off [LANES];
    logic [OFF_W-1:0]     w_total;

    assign w_mask_ext = MAX_LANES'(i_mask);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_off[i] = OFF_W'(ones_below(w_mask_ext, i));
            // Offsets are dense from zero, so "offset < limit" keeps exactly
            // the lowest-indexed limit accepted lanes.
            assign o_keep[i] = i_mask[i] && (w_off[i] < i_limit);
            assign o_offset[i*OFF_W +: OFF_W] = w_off[i];
            assign o_lane_data[i*CAND_BITS +: CAND_BITS] =
                o_keep[i] ? i_data[i*CAND_BITS +: CAND_BITS] : '0;
        end
    endgenerate

    assign w_total = OFF_W'(popcount(w_mask_ext));
    assign o_n_acc = (w_total < i_limit) ? w_total : i_limit;

endmodule
`default_nettype wire

// File: rtl/uniform_compactor.sv
`default_nettype none
// ============================================================================
//  Module      : uniform_compactor
//  Description : Consumer end of the uniform rejection-sampling path. Takes
//                LANES-wide candidate beats with an accept mask, packs the
//                accepted coefficients in lane order into a circular buffer,
//                and emits dense OUT_LANES-wide beats until N_COEFFS
//                coefficients of one polynomial are delivered, then pulses
//                done.
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                start          begin / restart a polynomial (one-cycle pulse)
//                in_valid/in_ready, sampled_vals, accept_mask   input beat
//                out_valid/out_ready, out_data, out_idx          output beat
//                busy           high while filling a polynomial
//                done           one-cycle pulse after the last output beat
//  Revision    : 1.0  initial release
// ============================================================================
module uniform_compactor #(
    parameter int LANES     = 8,
    parameter int CAND_BITS = uniform_pkg::CAND_BITS,
    parameter int OUT_LANES = 4,
    parameter int BUF_DEPTH = 16,
    parameter int N_COEFFS  = uniform_pkg::KYBER_N
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*CAND_BITS-1:0]     sampled_vals,
    input  logic [LANES-1:0]               accept_mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_LANES*CAND_BITS-1:0] out_data,
    output logic [$clog2(N_COEFFS)-1:0]    out_idx,
    output logic                           busy,
    output logic                           done
);
    import uniform_pkg::*;

    localparam int c_ptr_w = $clog2(BUF_DEPTH);
    localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);
    localparam int c_idx_w = $clog2(N_COEFFS);
    localparam int c_w_w   = $clog2(N_COEFFS + 1);
    localparam int c_off_w = $clog2(LANES + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]           r_state;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_w_w-1:0]     r_written;
    logic [c_w_w-1:0]     r_emitted;
    logic [CAND_BITS-1:0] r_buf [BUF_DEPTH];

    logic                         w_in_ready;
    logic                         w_out_valid;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_last_pop;
    logic                         w_clear;
    logic [c_w_w-1:0]             w_remaining;
    logic [c_off_w-1:0]           w_limit;
    logic [LANES-1:0]             w_keep;
    logic [LANES*c_off_w-1:0]     w_offset;
    logic [LANES*CAND_BITS-1:0]   w_lane_data;
    logic [c_off_w-1:0]           w_n_acc;
    logic [c_cnt_w-1:0]           w_push_n;
    logic [c_cnt_w-1:0]           w_pop_n;

    // ------------------------------------------------------------------
    // Handshake qualification. Both depend on registered state only, so
    // there is no combinational path from out_ready to in_ready.
    // ------------------------------------------------------------------
    assign w_in_ready  = (r_state == c_st_fill) &&
                         (r_count <= c_cnt_w'(BUF_DEPTH - LANES)) &&
                         (r_written < c_w_w'(N_COEFFS));
    assign w_out_valid = (r_state == c_st_fill) &&
                         (r_count >= c_cnt_w'(OUT_LANES));

    // A start pulse while filling aborts: the beat offered in that cycle is
    // dropped and no output beat is consumed.
    assign w_push     = w_in_ready && in_valid && !start;
    assign w_pop      = w_out_valid && out_ready && !start;
    assign w_last_pop = w_pop && ((r_emitted + c_w_w'(OUT_LANES)) == c_w_w'(N_COEFFS));
    assign w_clear    = start || (r_state == c_st_done);

    // Never keep more lanes than the polynomial still needs.
    assign w_remaining = c_w_w'(N_COEFFS) - r_written;
    assign w_limit     = (w_remaining >= c_w_w'(LANES)) ? c_off_w'(LANES)
                                                        : c_off_w'(w_remaining);

    uniform_lane_packer #(
        .LANES     (LANES),
        .CAND_BITS (CAND_BITS),
        .OFF_W     (c_off_w)
    ) u_packer (
        .i_mask      (accept_mask),
        .i_data      (sampled_vals),
        .i_limit     (w_limit),
        .o_keep      (w_keep),
        .o_offset    (w_offset),
        .o_lane_data (w_lane_data),
        .o_n_acc     (w_n_acc)
    );

    assign w_push_n = w_push ? c_cnt_w'(w_n_acc) : '0;
    assign w_pop_n  = w_pop  ? c_cnt_w'(OUT_LANES) : '0;

    // ------------------------------------------------------------------
    // Buffer storage. Each kept lane lands at wr_ptr + its prefix offset;
    // the pointer wraps naturally modulo BUF_DEPTH. Contents need no reset
    // because out_data is forced to zero whenever it is not valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_push && w_keep[i]) begin
                r_buf[r_wr_ptr + c_ptr_w'(w_offset[i*c_off_w +: c_off_w])] <=
                    w_lane_data[i*CAND_BITS +: CAND_BITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state machine and pointers / counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_written <= '0;
            r_emitted <= '0;
        end else begin
            if (w_clear) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_written <= '0;
                r_emitted <= '0;
            end else if (r_state == c_st_fill) begin
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + c_ptr_w'(w_n_acc);
                    r_written <= r_written + c_w_w'(w_n_acc);
                end
                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + c_ptr_w'(OUT_LANES);
                    r_emitted <= r_emitted + c_w_w'(OUT_LANES);
                end
                r_count <= r_count + w_push_n - w_pop_n;
            end

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_fill;
                    end
                end
                c_st_fill: begin
                    if (w_last_pop) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= start ? c_st_fill : c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Slot j reads rd_ptr + j; rd_ptr only moves on a handshake,
    // so data and index stay stable under backpressure.
    // ------------------------------------------------------------------
    generate
        for (genvar j = 0; j < OUT_LANES; j++) begin : g_out_slot
            assign out_data[j*CAND_BITS +: CAND_BITS] =
                w_out_valid ? r_buf[r_rd_ptr + c_ptr_w'(j)] : '0;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_idx   = r_emitted[c_idx_w-1:0];
    assign busy      = (r_state == c_st_fill);
    assign done      = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_uniform_compactor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uniform_compactor
//  Description : Self-checking bench for uniform_compactor. Accepted input
//                coefficients are appended to an expected-coefficient queue;
//                a monitor pops OUT_LANES entries per output handshake and
//                compares data, index and the done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uniform_compactor;

    localparam int LANES = 8;
    localparam int CB    = 16;
    localparam int OL    = 4;
    localparam int DEPTH = 16;
    localparam int N     = 256;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*CB-1:0] sampled_vals = '0;
    logic [LANES-1:0]    accept_mask = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [OL*CB-1:0]    out_data;
    logic [7:0]          out_idx;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    uniform_compactor #(
        .LANES     (LANES),
        .CAND_BITS (CB),
        .OUT_LANES (OL),
        .BUF_DEPTH (DEPTH),
        .N_COEFFS  (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sampled_vals (sampled_vals),
        .accept_mask  (accept_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .busy         (busy),
        .done         (done)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [CB-1:0] exp_q[$];
    int          exp_idx = 0;
    int          model_written = 0;
    logic        exp_done = 1'b0;
    int          done_seen = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + scoreboard, evaluated mid-cycle where all DUT
    // outputs and bench inputs are stable until the next rising edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [OL*CB-1:0] exp_vec;
        if (rst) begin
            exp_q.delete();
            exp_idx       = 0;
            model_written = 0;
            exp_done      = 1'b0;
        end else begin
            check("done_pulse", done, exp_done);
            if (done) done_seen++;
            exp_done = 1'b0;
            if (start) begin
                exp_q.delete();
                exp_idx       = 0;
                model_written = 0;
            end else begin
                if (in_valid && in_ready) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (accept_mask[i] && model_written < N) begin
                            exp_q.push_back(sampled_vals[i*CB +: CB]);
                            model_written++;
                        end
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() < OL) begin
                        check("beat_underflow", exp_q.size(), OL);
                    end else begin
                        exp_vec = '0;
                        for (int j = 0; j < OL; j++) exp_vec[j*CB +: CB] = exp_q.pop_front();
                        check("out_data", out_data, exp_vec);
                    end
                    check("out_idx", out_idx, exp_idx[7:0]);
                    exp_idx += OL;
                    if (exp_idx == N) begin
                        exp_done = 1'b1;
                        check("leftover_coeffs", exp_q.size(), 0);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [LANES*CB-1:0] seq_vals(input int base);
        logic [LANES*CB-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*CB +: CB] = CB'(base + i);
        return v;
    endfunction

    task automatic send_beat(input logic [LANES-1:0] m, input logic [LANES*CB-1:0] v);
        int budget;
        budget       = 0;
        in_valid     = 1'b1;
        accept_mask  = m;
        sampled_vals = v;
        while (!in_ready && budget < 200) begin
            tick();
            budget++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        while ((busy || done) && budget < 2000) begin
            tick();
            budget++;
        end
        check(name, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OL*CB-1:0] held;
        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_idx", out_idx, 8'd0);
        @(posedge clk); #3; rst = 1'b0;
        tick(); tick();
        check("idle_in_ready", in_ready, 1'b0);

        // ---------------- full polynomial, all lanes accepted ----------------
        out_ready = 1'b1;
        done_seen = 0;
        pulse_start();
        for (int b = 0; b < 32; b++) send_beat(8'hFF, seq_vals(8 * b));
        wait_idle("full_idle");
        check("full_done_count", done_seen, 1);
        check("full_in_ready_after", in_ready, 1'b0);

        // ---------------- sparse mask 0xA5 ----------------
        pulse_start();
        send_beat(8'hA5, seq_vals(16'h10));
        check("a5_valid_latency", out_valid, 1'b1);
        check("a5_first_beat", out_data, 64'h0017_0015_0012_0010);
        send_beat(8'hFF, seq_vals(16'h20));
        repeat (4) tick();

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        pulse_start();
        send_beat(8'hFF, seq_vals(16'h100));
        send_beat(8'hFF, seq_vals(16'h108));
        held = out_data;
        in_valid = 1'b1; accept_mask = 8'hFF; sampled_vals = seq_vals(16'h110);
        repeat (3) begin
            tick();
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_data_stable", out_data, held);
        end
        out_ready = 1'b1;
        send_beat(8'hFF, seq_vals(16'h110));
        send_beat(8'hFF, seq_vals(16'h118));
        repeat (10) tick();

        // ---------------- truncation at N ----------------
        done_seen = 0;
        pulse_start();
        for (int b = 0; b < 31; b++) send_beat(8'hFF, seq_vals(8 * b));
        send_beat(8'h0F, seq_vals(248));
        send_beat(8'hFF, seq_vals(16'h200));
        check("trunc_in_ready_low", in_ready, 1'b0);
        wait_idle("trunc_idle");
        check("trunc_done_count", done_seen, 1);
        check("trunc_in_ready_after", in_ready, 1'b0);

        // ---------------- abort while filling ----------------
        pulse_start();
        send_beat(8'hFF, seq_vals(16'h300));
        tick(); tick();
        out_ready = 1'b0;
        send_beat(8'h3F, seq_vals(16'h310));
        start = 1'b1;
        in_valid = 1'b1; accept_mask = 8'hFF; sampled_vals = seq_vals(16'h320);
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_idx", out_idx, 8'd0);
        out_ready = 1'b1;
        send_beat(8'hFF, seq_vals(16'h400));
        repeat (4) tick();

        // ---------------- asynchronous reset mid-fill ----------------
        out_ready = 1'b0;
        pulse_start();
        send_beat(8'hFF, seq_vals(16'h500));
        send_beat(8'h0F, seq_vals(16'h508));
        check("pre_rst_out_valid", out_valid, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        @(posedge clk); #3;
        rst = 1'b0;
        in_valid = 1'b1; accept_mask = 8'hFF; sampled_vals = seq_vals(16'h600);
        tick(); tick();
        check("post_rst_in_ready", in_ready, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        in_valid = 1'b0;

        // ---------------- randomized polynomials ----------------
        rand_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            int cyc;
            done_seen = 0;
            cyc = 0;
            pulse_start();
            while (busy && cyc < 3000) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                accept_mask = LANES'($urandom);
                if ($urandom_range(0, 7) == 0) accept_mask = '0;
                for (int i = 0; i < LANES; i++) sampled_vals[i*CB +: CB] = CB'($urandom);
                start = (p == 1 && cyc == 40);
                tick();
                cyc++;
            end
            start = 1'b0;
            in_valid = 1'b0;
            wait_idle("rand_idle");
            check("rand_done_count", done_seen, 1);
        end
        rand_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
